// File: rtl/rf_read_arbiter.sv
// Round-robin issue arbiter: grants up to NUM_SLOTS ready requesters per cycle,
// packs their RF operand reads onto RF_PORTS read ports and registers per-lane control.
module rf_read_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_SLOTS = 2,
   parameter int RF_PORTS  = 3,
   parameter int PREG_W    = 6,
   parameter int TAG_W     = 4
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_flush,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ-1:0]            i_req_op1_ready,
   input  logic [NUM_REQ-1:0]            i_req_op2_ready,
   input  logic [NUM_REQ*PREG_W-1:0]     i_req_rs1,
   input  logic [NUM_REQ*PREG_W-1:0]     i_req_rs2,
   input  logic [NUM_REQ*TAG_W-1:0]      i_req_robtag,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic [RF_PORTS-1:0]           o_rf_ren,
   output logic [RF_PORTS*PREG_W-1:0]    o_rf_raddr,
   input  logic                          i_out_ready,
   output logic [NUM_SLOTS-1:0]          o_slot_valid,
   output logic [NUM_SLOTS*2-1:0]        o_slot_req_id,
   output logic [NUM_SLOTS*TAG_W-1:0]    o_slot_robtag,
   output logic [NUM_SLOTS-1:0]          o_slot_op1_rd,
   output logic [NUM_SLOTS-1:0]          o_slot_op2_rd,
   output logic [NUM_SLOTS*2-1:0]        o_slot_op1_port,
   output logic [NUM_SLOTS*2-1:0]        o_slot_op2_port
);

   localparam int RW = 2;
   localparam int PW = 2;

   logic                        w_advance;
   logic                        w_enable;
   logic                        w_stop;
   logic                        w_any;
   logic                        w_cand;
   logic                        w_fit;
   int                          w_idx;
   int                          w_need;
   int                          w_ports;
   int                          w_lanes;
   int                          w_last;
   logic [RW-1:0]               w_rr_next;
   logic [NUM_REQ-1:0]          w_grant;
   logic [RF_PORTS-1:0]         w_ren;
   logic [RF_PORTS*PREG_W-1:0]  w_raddr;
   logic [NUM_SLOTS-1:0]        w_nx_valid;
   logic [NUM_SLOTS*RW-1:0]     w_nx_req_id;
   logic [NUM_SLOTS*TAG_W-1:0]  w_nx_robtag;
   logic [NUM_SLOTS-1:0]        w_nx_op1_rd;
   logic [NUM_SLOTS-1:0]        w_nx_op2_rd;
   logic [NUM_SLOTS*PW-1:0]     w_nx_op1_port;
   logic [NUM_SLOTS*PW-1:0]     w_nx_op2_port;

   logic [RW-1:0]               r_rr_ptr;
   logic [NUM_SLOTS-1:0]        r_slot_valid;
   logic [NUM_SLOTS*RW-1:0]     r_slot_req_id;
   logic [NUM_SLOTS*TAG_W-1:0]  r_slot_robtag;
   logic [NUM_SLOTS-1:0]        r_slot_op1_rd;
   logic [NUM_SLOTS-1:0]        r_slot_op2_rd;
   logic [NUM_SLOTS*PW-1:0]     r_slot_op1_port;
   logic [NUM_SLOTS*PW-1:0]     r_slot_op2_port;

   // Round-robin grant scan with in-order port packing; stops at the first requester that does not fit.
   always_comb begin
      w_advance     = i_out_ready || (r_slot_valid == {NUM_SLOTS{1'b0}});
      w_enable      = i_reset && !i_flush && w_advance;
      w_stop        = 1'b0;
      w_any         = 1'b0;
      w_cand        = 1'b0;
      w_fit         = 1'b0;
      w_idx         = 0;
      w_need        = 0;
      w_ports       = 0;
      w_lanes       = 0;
      w_last        = 0;
      w_grant       = {NUM_REQ{1'b0}};
      w_ren         = {RF_PORTS{1'b0}};
      w_raddr       = {(RF_PORTS*PREG_W){1'b0}};
      w_nx_valid    = {NUM_SLOTS{1'b0}};
      w_nx_req_id   = {(NUM_SLOTS*RW){1'b0}};
      w_nx_robtag   = {(NUM_SLOTS*TAG_W){1'b0}};
      w_nx_op1_rd   = {NUM_SLOTS{1'b0}};
      w_nx_op2_rd   = {NUM_SLOTS{1'b0}};
      w_nx_op1_port = {(NUM_SLOTS*PW){1'b0}};
      w_nx_op2_port = {(NUM_SLOTS*PW){1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx  = (int'(r_rr_ptr) + k) % NUM_REQ;
         w_need = (i_req_op1_ready[w_idx] ? 0 : 1) + (i_req_op2_ready[w_idx] ? 0 : 1);
         w_cand = w_enable && !w_stop && i_req_valid[w_idx];
         w_fit  = (w_lanes < NUM_SLOTS) && ((w_ports + w_need) <= RF_PORTS);
         w_stop = w_stop || (w_cand && !w_fit);
         if (w_cand && w_fit) begin
            w_grant[w_idx]                   = 1'b1;
            w_nx_valid[w_lanes]              = 1'b1;
            w_nx_req_id[w_lanes*RW +: RW]    = RW'(w_idx);
            w_nx_robtag[w_lanes*TAG_W +: TAG_W] = i_req_robtag[w_idx*TAG_W +: TAG_W];
            if (!i_req_op1_ready[w_idx]) begin
               w_ren[w_ports]                      = 1'b1;
               w_raddr[w_ports*PREG_W +: PREG_W]   = i_req_rs1[w_idx*PREG_W +: PREG_W];
               w_nx_op1_rd[w_lanes]                = 1'b1;
               w_nx_op1_port[w_lanes*PW +: PW]     = PW'(w_ports);
               w_ports                             = w_ports + 1;
            end else begin
               w_nx_op1_rd[w_lanes]                = 1'b0;
            end
            if (!i_req_op2_ready[w_idx]) begin
               w_ren[w_ports]                      = 1'b1;
               w_raddr[w_ports*PREG_W +: PREG_W]   = i_req_rs2[w_idx*PREG_W +: PREG_W];
               w_nx_op2_rd[w_lanes]                = 1'b1;
               w_nx_op2_port[w_lanes*PW +: PW]     = PW'(w_ports);
               w_ports                             = w_ports + 1;
            end else begin
               w_nx_op2_rd[w_lanes]                = 1'b0;
            end
            w_lanes = w_lanes + 1;
            w_last  = w_idx;
            w_any   = 1'b1;
         end else begin
            w_grant[w_idx] = 1'b0;
         end
      end
      w_rr_next = RW'((w_last + 1) % NUM_REQ);
   end

   // Round-robin pointer: moves past the last granted requester.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_rr_ptr <= {RW{1'b0}};
      end else if (w_any) begin
         r_rr_ptr <= w_rr_next;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end

   // Lane registers: flush clears, advance loads this cycle's grants, otherwise hold.
   always_ff @(posedge i_clock) begin
      if (!i_reset || i_flush) begin
         r_slot_valid    <= {NUM_SLOTS{1'b0}};
         r_slot_req_id   <= {(NUM_SLOTS*RW){1'b0}};
         r_slot_robtag   <= {(NUM_SLOTS*TAG_W){1'b0}};
         r_slot_op1_rd   <= {NUM_SLOTS{1'b0}};
         r_slot_op2_rd   <= {NUM_SLOTS{1'b0}};
         r_slot_op1_port <= {(NUM_SLOTS*PW){1'b0}};
         r_slot_op2_port <= {(NUM_SLOTS*PW){1'b0}};
      end else if (w_advance) begin
         r_slot_valid    <= w_nx_valid;
         r_slot_req_id   <= w_nx_req_id;
         r_slot_robtag   <= w_nx_robtag;
         r_slot_op1_rd   <= w_nx_op1_rd;
         r_slot_op2_rd   <= w_nx_op2_rd;
         r_slot_op1_port <= w_nx_op1_port;
         r_slot_op2_port <= w_nx_op2_port;
      end else begin
         r_slot_valid    <= r_slot_valid;
         r_slot_req_id   <= r_slot_req_id;
         r_slot_robtag   <= r_slot_robtag;
         r_slot_op1_rd   <= r_slot_op1_rd;
         r_slot_op2_rd   <= r_slot_op2_rd;
         r_slot_op1_port <= r_slot_op1_port;
         r_slot_op2_port <= r_slot_op2_port;
      end
   end

   assign o_grant         = w_grant;
   assign o_rf_ren        = w_ren;
   assign o_rf_raddr      = w_raddr;
   assign o_slot_valid    = r_slot_valid;
   assign o_slot_req_id   = r_slot_req_id;
   assign o_slot_robtag   = r_slot_robtag;
   assign o_slot_op1_rd   = r_slot_op1_rd;
   assign o_slot_op2_rd   = r_slot_op2_rd;
   assign o_slot_op1_port = r_slot_op1_port;
   assign o_slot_op2_port = r_slot_op2_port;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed self-checking bench for rf_read_arbiter: rs1=10+i, rs2=20+i, robtag=4+i per requester.
module tb_rf_read_arbiter;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [3:0]  req_valid;
   logic [3:0]  op1_rdy;
   logic [3:0]  op2_rdy;
   logic [23:0] rs1;
   logic [23:0] rs2;
   logic [15:0] robtag;
   logic [3:0]  grant;
   logic [2:0]  rf_ren;
   logic [17:0] rf_raddr;
   logic        out_ready;
   logic [1:0]  slot_valid;
   logic [3:0]  slot_req_id;
   logic [7:0]  slot_robtag;
   logic [1:0]  slot_op1_rd;
   logic [1:0]  slot_op2_rd;
   logic [3:0]  slot_op1_port;
   logic [3:0]  slot_op2_port;

   int n_tests = 0;
   int n_fail  = 0;

   rf_read_arbiter dut (
      .i_clock(clk), .i_reset(rst_n), .i_flush(flush),
      .i_req_valid(req_valid), .i_req_op1_ready(op1_rdy), .i_req_op2_ready(op2_rdy),
      .i_req_rs1(rs1), .i_req_rs2(rs2), .i_req_robtag(robtag),
      .o_grant(grant), .o_rf_ren(rf_ren), .o_rf_raddr(rf_raddr),
      .i_out_ready(out_ready),
      .o_slot_valid(slot_valid), .o_slot_req_id(slot_req_id), .o_slot_robtag(slot_robtag),
      .o_slot_op1_rd(slot_op1_rd), .o_slot_op2_rd(slot_op2_rd),
      .o_slot_op1_port(slot_op1_port), .o_slot_op2_port(slot_op2_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] r1, input logic [3:0] r2,
                        input logic ordy, input logic fl, input logic rn);
      req_valid = v; op1_rdy = r1; op2_rdy = r2; out_ready = ordy; flush = fl; rst_n = rn;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rs1[i*6 +: 6]    = 6'(10 + i);
         rs2[i*6 +: 6]    = 6'(20 + i);
         robtag[i*4 +: 4] = 4'(4 + i);
      end

      // reset held low with all requests valid
      drive(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_ren", 32'(rf_ren), 32'h0);
      chk("rst_raddr", 32'(rf_raddr), 32'h0);
      tick();
      tick();
      chk("rst_slot_valid", 32'(slot_valid), 32'h0);
      chk("rst_slot_req_id", 32'(slot_req_id), 32'h0);

      // all need 2 reads: only requester 0 fits
      drive(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
      chk("a_grant", 32'(grant), 32'b0001);
      chk("a_ren", 32'(rf_ren), 32'b011);
      chk("a_raddr", 32'(rf_raddr), 32'({6'd0, 6'd20, 6'd10}));
      tick();
      chk("a_slot_valid", 32'(slot_valid), 32'b01);
      chk("a_slot_req_id", 32'(slot_req_id), 32'h0);
      chk("a_slot_robtag", 32'(slot_robtag), 32'h04);
      chk("a_op1_rd", 32'(slot_op1_rd), 32'b01);
      chk("a_op2_rd", 32'(slot_op2_rd), 32'b01);
      chk("a_op1_port", 32'(slot_op1_port), 32'h0);
      chk("a_op2_port", 32'(slot_op2_port), 32'h1);

      // rr=1: req1 needs op2 only, req2 needs nothing
      drive(4'b0110, 4'b0110, 4'b0100, 1'b1, 1'b0, 1'b1);
      chk("b_grant", 32'(grant), 32'b0110);
      chk("b_ren", 32'(rf_ren), 32'b001);
      chk("b_raddr", 32'(rf_raddr), 32'd21);
      tick();
      chk("b_slot_valid", 32'(slot_valid), 32'b11);
      chk("b_slot_req_id", 32'(slot_req_id), 32'b1001);
      chk("b_slot_robtag", 32'(slot_robtag), 32'h65);
      chk("b_op1_rd", 32'(slot_op1_rd), 32'b00);
      chk("b_op2_rd", 32'(slot_op2_rd), 32'b01);
      chk("b_op2_port", 32'(slot_op2_port), 32'h0);

      // rr=3: lone need-0 requester 3 moves the pointer to 0
      drive(4'b1000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
      chk("c_grant", 32'(grant), 32'b1000);
      chk("c_ren", 32'(rf_ren), 32'b000);
      tick();

      // fairness: each needs one read (op2)
      for (int c = 0; c < 4; c++) begin
         drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
         if (c % 2 == 0) begin
            chk("fair_grant_lo", 32'(grant), 32'b0011);
            chk("fair_raddr_lo", 32'(rf_raddr), 32'({6'd0, 6'd21, 6'd20}));
         end else begin
            chk("fair_grant_hi", 32'(grant), 32'b1100);
            chk("fair_raddr_hi", 32'(rf_raddr), 32'({6'd0, 6'd23, 6'd22}));
         end
         chk("fair_ren", 32'(rf_ren), 32'b011);
         tick();
      end
      chk("fair_slot_req_id", 32'(slot_req_id), 32'b1110);

      // backpressure with both lanes full
      for (int c = 0; c < 3; c++) begin
         drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
         chk("bp_grant", 32'(grant), 32'h0);
         chk("bp_ren", 32'(rf_ren), 32'h0);
         tick();
         chk("bp_slot_valid", 32'(slot_valid), 32'b11);
         chk("bp_slot_req_id", 32'(slot_req_id), 32'b1110);
      end
      drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
      chk("bp_resume_grant", 32'(grant), 32'b0011);
      chk("bp_resume_ren", 32'(rf_ren), 32'b011);
      tick();
      chk("bp_resume_req_id", 32'(slot_req_id), 32'b0100);

      // flush: no grant, lanes clear, pointer kept at 2
      drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
      chk("fl_grant", 32'(grant), 32'h0);
      chk("fl_ren", 32'(rf_ren), 32'h0);
      chk("fl_raddr", 32'(rf_raddr), 32'h0);
      tick();
      chk("fl_slot_valid", 32'(slot_valid), 32'h0);
      chk("fl_slot_req_id", 32'(slot_req_id), 32'h0);
      drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
      chk("fl_after_grant", 32'(grant), 32'b1100);
      tick();
      chk("fl_after_valid", 32'(slot_valid), 32'b11);
      chk("fl_after_req_id", 32'(slot_req_id), 32'b1110);

      // mid-stream reset wins over flush and returns rr to 0
      drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
      chk("mr_grant", 32'(grant), 32'h0);
      tick();
      chk("mr_slot_valid", 32'(slot_valid), 32'h0);

      // empty lanes advance even with out_ready low
      drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
      chk("mr_grant_rr0", 32'(grant), 32'b0011);
      tick();
      chk("mr_slot_valid2", 32'(slot_valid), 32'b11);
      drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
      chk("stall_grant", 32'(grant), 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
